// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums kij_len passes of nij_len psum vectors into
// an on-chip buffer, then drains the totals with optional ReLU.

// One psum lane: accumulate-or-overwrite adder plus the ReLU read path.
module psum_lane #(
  parameter int psum_bw = 16,
  parameter int sat     = 0
) (
  input  logic [psum_bw-1:0] acc_i,
  input  logic [psum_bw-1:0] in_i,
  input  logic               first_i,
  input  logic [psum_bw-1:0] rd_i,
  input  logic               relu_i,
  output logic [psum_bw-1:0] sum_o,
  output logic [psum_bw-1:0] rd_o
);
  localparam logic [psum_bw-1:0] SMAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SMIN = {1'b1, {(psum_bw-1){1'b0}}};

  logic [psum_bw:0] ext;
  logic             ovf;

  // One extra bit exposes signed overflow: top two bits differ.
  assign ext = {acc_i[psum_bw-1], acc_i} + {in_i[psum_bw-1], in_i};
  assign ovf = ext[psum_bw] ^ ext[psum_bw-1];

  // First pass overwrites; later passes wrap or clamp on overflow.
  always_comb begin
    sum_o = ext[psum_bw-1:0];
    if (first_i)                  sum_o = in_i;
    else if ((sat != 0) && ovf)   sum_o = ext[psum_bw] ? SMIN : SMAX;
  end

  assign rd_o = (relu_i && rd_i[psum_bw-1]) ? '0 : rd_i;
endmodule

module psum_accumulator #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int nij_len = 16,
  parameter int kij_len = 9,
  parameter int sat     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   relu,
  input  logic                   in_valid,
  input  logic [col*psum_bw-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [col*psum_bw-1:0] out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);
  localparam int NW    = (nij_len > 1) ? $clog2(nij_len) : 1;
  localparam int KW    = (kij_len > 1) ? $clog2(kij_len) : 1;
  // Depth rounded to the pointer range so every index value is legal.
  localparam int DEPTH = 1 << NW;
  localparam logic [NW-1:0] NIJ_LAST = NW'(nij_len - 1);
  localparam logic [KW-1:0] KIJ_LAST = KW'(kij_len - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;
  typedef logic [col-1:0][psum_bw-1:0] vec_t;

  state_e        state_q, state_d;
  logic [NW-1:0] nij_q, nij_d, rd_q, rd_d;
  logic [KW-1:0] kij_q, kij_d;
  logic          relu_q, relu_d, done_q, done_d;

  vec_t mem_q [DEPTH];
  vec_t in_vec, acc_vec, sum_vec, rd_vec, rd_relu;
  logic in_xfer, out_xfer, first_pass;

  assign in_vec     = in_data;
  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == DRAIN);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  assign first_pass = (kij_q == '0);
  assign acc_vec    = mem_q[nij_q];
  assign rd_vec     = mem_q[rd_q];
  assign out_data   = out_valid ? rd_relu : '0;

  for (genvar c = 0; c < col; c++) begin : g_lane
    psum_lane #(.psum_bw(psum_bw), .sat(sat)) u_lane (
      .acc_i  (acc_vec[c]),
      .in_i   (in_vec[c]),
      .first_i(first_pass),
      .rd_i   (rd_vec[c]),
      .relu_i (relu_q),
      .sum_o  (sum_vec[c]),
      .rd_o   (rd_relu[c])
    );
  end

  // Next-state: run control, nij/kij counters, drain pointer, done pulse.
  always_comb begin
    state_d = state_q;
    nij_d   = nij_q;
    kij_d   = kij_q;
    rd_d    = rd_q;
    relu_d  = relu_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        relu_d  = relu;
        nij_d   = '0;
        kij_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: if (in_xfer) begin
        if (nij_q == NIJ_LAST) begin
          nij_d = '0;
          if (kij_q == KIJ_LAST) begin
            kij_d   = '0;
            rd_d    = '0;
            state_d = DRAIN;
          end else begin
            kij_d = kij_q + KW'(1);
          end
        end else begin
          nij_d = nij_q + NW'(1);
        end
      end
      DRAIN: if (out_xfer) begin
        if (rd_q == NIJ_LAST) begin
          rd_d    = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rd_d = rd_q + NW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      nij_q   <= '0;
      kij_q   <= '0;
      rd_q    <= '0;
      relu_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nij_q   <= nij_d;
      kij_q   <= kij_d;
      rd_q    <= rd_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
    end
  end

  // Psum buffer; no reset since the first pass overwrites every entry.
  always_ff @(posedge clk) begin
    if (in_xfer) mem_q[nij_q] <= sum_vec;
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: wrap and saturating instances share stimulus,
// outputs are checked against a pass-by-pass arithmetic model.
module tb_psum_accumulator;
  localparam int COL = 8, W = 16, NIJ = 16, KIJ = 9, NT = NIJ * KIJ, VW = COL * W;

  logic clk = 1'b0;
  logic reset, start, relu, in_valid, out_ready;
  logic [VW-1:0] in_data;
  logic in_ready0, out_valid0, busy0, done0, in_ready1, out_valid1, busy1, done1;
  logic [VW-1:0] out_data0, out_data1;

  logic [VW-1:0] vecs [NT];
  logic [VW-1:0] exp0 [NIJ];
  logic [VW-1:0] exp1 [NIJ];
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.sat(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .relu(relu), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_data(out_data0), .out_ready(out_ready), .busy(busy0), .done(done0));

  psum_accumulator #(.sat(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .relu(relu), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_ready(out_ready), .busy(busy1), .done(done1));

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Both instances must agree on handshake/status outputs.
  task automatic chk_ctl(input string tag, input bit rdy, input bit ov, input bit bz, input bit dn);
    chk({tag, ":in_ready"},  VW'({in_ready0, in_ready1}),   VW'({rdy, rdy}));
    chk({tag, ":out_valid"}, VW'({out_valid0, out_valid1}), VW'({ov, ov}));
    chk({tag, ":busy"},      VW'({busy0, busy1}),           VW'({bz, bz}));
    chk({tag, ":done"},      VW'({done0, done1}),           VW'({dn, dn}));
  endtask

  task automatic fill_const(input logic [W-1:0] v);
    for (int i = 0; i < NT; i++) vecs[i] = {COL{v}};
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NT; i++) vecs[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference: per pixel and lane, sum the kij passes as integers; the
  // wrap copy truncates to 16 bits each step, the sat copy clamps each step.
  task automatic build_exp(input bit rl);
    for (int n = 0; n < NIJ; n++)
      for (int l = 0; l < COL; l++) begin
        int a0, a1, x;
        a0 = 0; a1 = 0;
        for (int k = 0; k < KIJ; k++) begin
          x = int'(shortint'(vecs[k*NIJ + n][l*W +: W]));
          if (k == 0) begin a0 = x; a1 = x; end
          else begin
            a0 = int'(shortint'(a0 + x));
            a1 = a1 + x;
            if (a1 > 32767)  a1 = 32767;
            if (a1 < -32768) a1 = -32768;
          end
        end
        if (rl && a0 < 0) a0 = 0;
        if (rl && a1 < 0) a1 = 0;
        exp0[n][l*W +: W] = 16'(a0);
        exp1[n][l*W +: W] = 16'(a1);
      end
  endtask

  // Full run: start (unless already issued), feed NT vectors with random
  // gaps, drain with optional 5-cycle stalls, check done. Each step begins
  // and ends on a falling edge.
  task automatic do_run(input string name, input bit rl, input int gap_pct, input int stall_pct,
                        input bit chain, input bit pre, input bit poke);
    int idx, guard;
    bit v;
    build_exp(rl);
    if (!pre) begin
      @(negedge clk); start = 1'b1; relu = rl;
    end
    @(negedge clk); start = 1'b0; relu = 1'b0;
    idx = 0; guard = 0;
    while (idx < NT && guard < 5000) begin
      v = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = v ? vecs[idx] : {$urandom, $urandom, $urandom, $urandom};
      start    = (poke && idx == 20);
      if (idx == 0 || idx == NT - 1 || poke) chk_ctl({name, ":accum"}, 1'b1, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      if (v) idx++;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (guard >= 5000) chk({name, ":feed_timeout"}, VW'(idx), VW'(NT));
    // Garbage offered while draining must not reach the buffer.
    in_valid = 1'b1;
    for (int n = 0; n < NIJ; n++) begin
      int st;
      st = ($urandom_range(99) < stall_pct) ? 5 : 0;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      for (int s = 0; s < st; s++) begin
        out_ready = 1'b0;
        chk({name, ":stall_data0"}, out_data0, exp0[n]);
        chk({name, ":stall_data1"}, out_data1, exp1[n]);
        chk({name, ":stall_valid"}, VW'({out_valid0, out_valid1}), VW'(2'b11));
        @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b1;
      chk_ctl({name, ":drain"}, 1'b0, 1'b1, 1'b1, 1'b0);
      chk({name, ":data0"}, out_data0, exp0[n]);
      chk({name, ":data1"}, out_data1, exp1[n]);
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk_ctl({name, ":done"}, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({name, ":idle_data"}, out_data0 | out_data1, '0);
    if (chain) begin
      start = 1'b1; relu = 1'b0;
    end else begin
      @(posedge clk); @(negedge clk);
      chk_ctl({name, ":after"}, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; relu = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #4;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset:out_data", out_data0 | out_data1, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    fill_const(16'h0001); do_run("ones",      1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("ones:value", exp0[0], {COL{16'h0009}});
    fill_const(16'h4000); do_run("big",       1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    fill_const(16'hFFFF); do_run("neg",       1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    fill_const(16'hFFFF); do_run("neg_relu",  1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    fill_rand();          do_run("gaps_stall", 1'b0, 40, 50, 1'b0, 1'b0, 1'b0);
    fill_rand();          do_run("rand_relu", 1'b1, 20, 30, 1'b0, 1'b0, 1'b0);

    // Start while busy is ignored; start on the done cycle chains a run.
    fill_rand();          do_run("poke",      1'b0, 10, 20, 1'b1, 1'b0, 1'b1);
    fill_const(16'h0003); do_run("chained",   1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Abort after 40 inputs.
    fill_rand();
    @(negedge clk); start = 1'b1; relu = 1'b1;
    @(negedge clk); start = 1'b0; relu = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = vecs[i];
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_ctl("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort:out_data", out_data0 | out_data1, '0);
    @(negedge clk);
    chk_ctl("abort_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_ctl("abort_after", 1'b0, 1'b0, 1'b0, 1'b0);
    fill_const(16'h0002); do_run("restart",   1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("restart:value", exp0[NIJ-1], {COL{16'h0012}});

    for (int r = 0; r < 3; r++) begin
      fill_rand();
      do_run("random", 1'($urandom_range(1)), 25, 25, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
